dma_ext_sink: RTL and testbench
===============================

Name: dma_ext_sink

Overview:
- External-device model that sits directly downstream of the DMA controller.
- After a programmable delay it raises an interrupt asking the CPU to start a DMA transfer.
- It captures each memory word the DMA streams out (mtoe qualified, addressed by index) into a local buffer and tracks which slots have been filled.
- On dma_end it checks completeness, reports done/error and returns to idle; the CPU and bench read the buffer back through a read port.

Parameters:
- WORD_SIZE, 16, data width in bits.
- DEPTH, 12, buffer slots; equals the programmed DMA length.
- IDX_W, 6, index width; matches the DMA index output.
- TRIG_DELAY, 200, cycles from arm to interrupt assertion (legal range 1..65535).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse, starts a new transfer session.
- interrupt  out  1  DMA request to the CPU.
- mtoe  in  1  memory-to-external-device strobe from the DMA.
- index  in  IDX_W  buffer slot for the current word.
- data_in  in  WORD_SIZE  memory data bus word.
- dma_end  in  1  one-cycle end-of-transfer pulse from the DMA.
- rd_addr  in  IDX_W  readback slot address.
- rd_data  out  WORD_SIZE  combinational buffer readback; 0 when rd_addr >= DEPTH.
- word_count  out  IDX_W  number of distinct slots written this session.
- busy  out  1  high in WAIT, IRQ and RECV.
- done  out  1  one-cycle pulse at the end of a session.
- error  out  1  sticky until the next arm.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; interrupt=0, busy=0, done=0, error=0, word_count=0.
  - Delay counter=0; valid bitmap all 0.
  - Buffer contents are cleared to 0.
- States: IDLE, WAIT, IRQ, RECV.
- IDLE:
  - arm=1 -> WAIT; load counter with TRIG_DELAY-1; clear bitmap, word_count and error.
  - Buffer data is retained.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter is 0 -> IRQ, with interrupt=1 the next cycle. Interrupt therefore first appears exactly TRIG_DELAY cycles after the arm edge.
- IRQ:
  - interrupt held at 1 until the first cycle with mtoe=1; that cycle -> RECV, interrupt=0 next cycle.
  - The word presented on that cycle is captured.
- RECV, on each posedge with mtoe=1 and index<DEPTH:
  - buf[index] <= data_in.
  - If valid[index]==0: set valid[index] and increment word_count.
  - Repeated indices are legal (the DMA presents index 0 on two consecutive beats); they overwrite data but do not recount.
- Out-of-range write: mtoe=1 with index>=DEPTH -> no write, error<=1.
- dma_end=1 in RECV:
  - -> IDLE; done=1 for one cycle; busy drops the same edge.
  - If the final word_count (including a write in the same cycle) != DEPTH, error<=1.
  - A write with mtoe and dma_end in the same cycle is still captured and counted.
- dma_end=1 in WAIT or IRQ: protocol error; error<=1, -> IDLE, done=1, interrupt=0.
- mtoe=1 in IDLE or WAIT: ignored, no write; error<=1 only in WAIT.
- arm while busy: ignored.
- arm and dma_end in the same cycle while in RECV: dma_end wins; arm is dropped.
- Reset mid-session: immediate return to IDLE with all outputs at reset values; the partial buffer is discarded (cleared).
- Width rules:
  - word_count saturates at DEPTH; it cannot exceed DEPTH by construction.
  - Counter width is 16 bits.
- Readback: rd_data is combinational from buf[rd_addr]; a same-cycle write is visible after the edge.

Decomposition:
- Shared package/header: WORD_SIZE define, state encodings (IDLE=2'd0, WAIT=2'd1, IRQ=2'd2, RECV=2'd3), default DEPTH and IDX_W values shared with the DMA and CPU top.
- One natural sub-module: dma_sink_buffer, the DEPTH x WORD_SIZE register file with valid bitmap, write port, new-slot flag output and combinational read port.
- FSM, counter and status flags stay in dma_ext_sink.

Test Plan:
- Basic timing: reset, arm at cycle 10, TRIG_DELAY=5 -> interrupt rises at cycle 15 and stays high until the first mtoe.
- Nominal transfer: mtoe beats with index 0,0,1,...,11 and data 16'hA000+index, then dma_end.
  - word_count=12, done pulses once, error=0.
  - rd_addr=11 returns 16'hA00B; rd_addr=0 returns 16'hA000.
- Short transfer: only indices 0..9 written, then dma_end -> word_count=10, done=1, error=1; error stays high until the next arm.
- Out-of-range index: mtoe with index=12, data 16'hDEAD -> no slot changes, error=1, word_count unchanged.
- Premature end: dma_end during WAIT -> state IDLE, done pulse, error=1, interrupt never asserts.
- Reset mid-RECV: after 5 words, reset_n=0 for one cycle -> busy=0, word_count=0, rd_data=0 for all slots; a fresh arm completes a full 12-word session cleanly.

Source files
------------

// File: rtl/dma_ext_sink_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dma_ext_sink_pkg
//  Purpose  : Shared constants and state encoding for the DMA external-device
//             sink model. The default sizes match the DMA controller and the
//             CPU top so that all three agree on word width, length and index
//             width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package dma_ext_sink_pkg;

    localparam int c_word_size  = 16;   // memory data bus width
    localparam int c_depth      = 12;   // DMA transfer length / buffer slots
    localparam int c_idx_w      = 6;    // width of the DMA index output
    localparam int c_trig_delay = 200;  // arm-to-interrupt delay in cycles
    localparam int c_cnt_w      = 16;   // delay counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_IRQ  = 2'd2,
        ST_RECV = 2'd3
    } sink_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_sink_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : dma_sink_buffer
//  Purpose  : DEPTH x WORD_SIZE register file with a per-slot valid bitmap.
//             A write to an in-range slot stores the word and marks the slot
//             valid; new_slot flags (combinationally) that the pending write
//             lands on a slot not yet written since the last clr_valid.
//             Out-of-range write indices are silently dropped here.
//  Ports    : clk, reset_n   - clock, async active-low reset (clears data too)
//             clr_valid      - clear the valid bitmap (data retained)
//             wr_en/wr_idx/wr_data - write port
//             new_slot       - pending write hits an unwritten slot
//             rd_addr/rd_data- combinational read, 0 when out of range
//  Revision : 1.0  initial release
// ============================================================================
module dma_sink_buffer
    import dma_ext_sink_pkg::*;
#(
    parameter int WORD_SIZE = c_word_size,
    parameter int DEPTH     = c_depth,
    parameter int IDX_W     = c_idx_w
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr_valid,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic                 new_slot,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]     r_valid;

    // Slot decode by comparison so indices >= DEPTH match nothing.
    always_comb begin
        new_slot = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_idx == IDX_W'(i) && !r_valid[i]) begin
                new_slot = wr_en;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == IDX_W'(i)) begin
                rd_data = r_mem[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            if (clr_valid) begin
                r_valid <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    r_mem[i]   <= wr_data;
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_ext_sink.sv
`default_nettype none
// ============================================================================
//  Module   : dma_ext_sink
//  Purpose  : External-device model downstream of the DMA controller. After
//             arm it waits TRIG_DELAY cycles, raises interrupt, captures the
//             words the DMA streams out (mtoe strobe, slot = index) and on
//             dma_end reports done and, if the session was incomplete or
//             malformed, a sticky error.
//  Ports    : clk, reset_n        - clock, async active-low reset
//             arm                 - start a session (ignored while busy)
//             interrupt           - DMA request to the CPU
//             mtoe/index/data_in  - DMA write strobe, slot and data
//             dma_end             - end-of-transfer pulse
//             rd_addr/rd_data     - combinational buffer readback
//             word_count          - distinct slots written this session
//             busy/done/error     - session status
//  Revision : 1.0  initial release
// ============================================================================
module dma_ext_sink
    import dma_ext_sink_pkg::*;
#(
    parameter int WORD_SIZE  = c_word_size,
    parameter int DEPTH      = c_depth,
    parameter int IDX_W      = c_idx_w,
    parameter int TRIG_DELAY = c_trig_delay
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arm,
    output logic                 interrupt,
    input  logic                 mtoe,
    input  logic [IDX_W-1:0]     index,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 dma_end,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic [IDX_W-1:0]     word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    sink_state_e          r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_interrupt;
    logic                 r_done;
    logic                 r_error;
    logic [IDX_W-1:0]     r_word_count;

    logic                 w_in_range;
    logic                 w_rx_state;
    logic                 w_wr_en;
    logic                 w_clr_valid;
    logic                 w_new_slot;

    assign w_in_range  = (index < IDX_W'(DEPTH));
    // The first mtoe beat seen in IRQ is captured as well as every RECV beat.
    assign w_rx_state  = (r_state == ST_IRQ) || (r_state == ST_RECV);
    assign w_wr_en     = mtoe && w_rx_state && w_in_range;
    assign w_clr_valid = (r_state == ST_IDLE) && arm;

    dma_sink_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_valid (w_clr_valid),
        .wr_en     (w_wr_en),
        .wr_idx    (index),
        .wr_data   (data_in),
        .new_slot  (w_new_slot),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_interrupt  <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_new_slot && r_word_count != IDX_W'(DEPTH)) begin
                r_word_count <= r_word_count + IDX_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_state      <= ST_WAIT;
                        r_cnt        <= c_cnt_w'(TRIG_DELAY - 1);
                        r_word_count <= '0;
                        r_error      <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    if (dma_end) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                    end else begin
                        if (mtoe) begin
                            r_error <= 1'b1;
                        end
                        // Counter was loaded with TRIG_DELAY-1 so interrupt
                        // becomes visible exactly TRIG_DELAY edges after arm.
                        if (r_cnt == '0) begin
                            r_state     <= ST_IRQ;
                            r_interrupt <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_w'(1);
                        end
                    end
                end

                ST_IRQ: begin
                    if (dma_end) begin
                        r_state     <= ST_IDLE;
                        r_done      <= 1'b1;
                        r_error     <= 1'b1;
                        r_interrupt <= 1'b0;
                    end else if (mtoe) begin
                        r_state     <= ST_RECV;
                        r_interrupt <= 1'b0;
                        if (!w_in_range) begin
                            r_error <= 1'b1;
                        end
                    end
                end

                ST_RECV: begin
                    if (mtoe && !w_in_range) begin
                        r_error <= 1'b1;
                    end
                    if (dma_end) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        // Include a write landing on the same edge.
                        if ((r_word_count + IDX_W'(w_new_slot)) != IDX_W'(DEPTH)) begin
                            r_error <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign interrupt  = r_interrupt;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_word_count;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dma_ext_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_ext_sink
//  Purpose  : Self-checking bench for dma_ext_sink. A session-level model
//             (slot array, written-slot set, distinct count, error flag) gives
//             the expected outputs for table-driven, hand-written and random
//             transfer sessions.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dma_ext_sink;

    localparam int WS    = 16;
    localparam int DEPTH = 12;
    localparam int IDX_W = 6;
    localparam int TD    = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             arm = 1'b0;
    logic             mtoe = 1'b0;
    logic [IDX_W-1:0] index = '0;
    logic [WS-1:0]    data_in = '0;
    logic             dma_end = 1'b0;
    logic [IDX_W-1:0] rd_addr = '0;
    logic             interrupt;
    logic [WS-1:0]    rd_data;
    logic [IDX_W-1:0] word_count;
    logic             busy;
    logic             done;
    logic             error;

    dma_ext_sink #(
        .WORD_SIZE  (WS),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .TRIG_DELAY (TD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .arm        (arm),
        .interrupt  (interrupt),
        .mtoe       (mtoe),
        .index      (index),
        .data_in    (data_in),
        .dma_end    (dma_end),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Session-level reference model
    logic [WS-1:0] m_mem [DEPTH];
    bit            m_valid [DEPTH];
    int            m_count;
    bit            m_err;

    typedef struct {
        int          n_words;   // indices 0..n_words-1 sent in order
        bit          dup0;      // index 0 presented twice up front
        bit          oor;       // one index-12 beat (data DEAD) inserted
        logic [15:0] base;      // data = base + index
        int          exp_count;
        bit          exp_error;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_clear_mem();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_count = 0;
        m_err   = 1'b0;
        check("arm_busy", busy, 1);
        check("arm_err_clear", error, 0);
        check("arm_wc_clear", word_count, 0);
    endtask

    task automatic wait_irq(input int exp_cycles);
        int k;
        k = 0;
        while (interrupt !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("irq_delay", k, exp_cycles);
    endtask

    task automatic start_session();
        arm_pulse();
        wait_irq(TD);
    endtask

    task automatic beat(input int idx, input logic [WS-1:0] d, input bit last);
        mtoe    = 1'b1;
        index   = idx[IDX_W-1:0];
        data_in = d;
        dma_end = last;
        tick();
        mtoe    = 1'b0;
        dma_end = 1'b0;
        if (idx < DEPTH) begin
            m_mem[idx] = d;
            if (!m_valid[idx]) begin
                m_valid[idx] = 1'b1;
                m_count++;
            end
        end else begin
            m_err = 1'b1;
        end
        if (last && m_count != DEPTH) m_err = 1'b1;
        check("beat_wc", word_count, m_count);
        check("beat_irq_low", interrupt, 0);
        check("beat_done", done, last);
        check("beat_busy", busy, !last);
        check("beat_error", error, m_err);
    endtask

    task automatic end_only();
        dma_end = 1'b1;
        tick();
        dma_end = 1'b0;
        if (m_count != DEPTH) m_err = 1'b1;
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_error", error, m_err);
        check("end_wc", word_count, m_count);
    endtask

    task automatic readback();
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = i[IDX_W-1:0];
            #1;
            check($sformatf("rd[%0d]", i), rd_data, m_mem[i]);
        end
        rd_addr = 6'd12;
        #1;
        check("rd_oor12", rd_data, 0);
        rd_addr = 6'd63;
        #1;
        check("rd_oor63", rd_data, 0);
    endtask

    task automatic post_end();
        tick();
        check("done_one_cycle", done, 0);
        readback();
    endtask

    task automatic full_session(input logic [15:0] base);
        start_session();
        beat(0, base, 1'b0);
        for (int i = 0; i < DEPTH; i++) beat(i, base + 16'(i), i == DEPTH - 1);
        post_end();
    endtask

    initial begin
        int q[$];
        int perm[DEPTH];
        bit irq_seen;

        tbl[0] = '{12, 1'b1, 1'b0, 16'hA000, 12, 1'b0};
        tbl[1] = '{10, 1'b1, 1'b0, 16'hB000, 10, 1'b1};
        tbl[2] = '{12, 1'b0, 1'b1, 16'hC000, 12, 1'b1};
        tbl[3] = '{ 1, 1'b0, 1'b0, 16'hD000,  1, 1'b1};
        tbl[4] = '{12, 1'b1, 1'b0, 16'hE000, 12, 1'b0};

        // ---------------- reset state
        model_clear_mem();
        m_count = 0;
        m_err   = 1'b0;
        idle(3);
        check("rst_interrupt", interrupt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_wc", word_count, 0);
        reset_n = 1'b1;
        idle(6);
        readback();

        // ---------------- table-driven sessions
        for (int v = 0; v < 5; v++) begin
            start_session();
            idle(3);
            check("irq_held", interrupt, 1);
            q.delete();
            if (tbl[v].dup0) q.push_back(0);
            for (int i = 0; i < tbl[v].n_words; i++) q.push_back(i);
            if (tbl[v].oor) q.insert(3, 12);
            for (int j = 0; j < q.size(); j++) begin
                beat(q[j], (q[j] == 12) ? 16'hDEAD : tbl[v].base + 16'(q[j]), j == q.size() - 1);
            end
            check("tbl_wc", word_count, tbl[v].exp_count);
            check("tbl_error", error, tbl[v].exp_error);
            post_end();
            if (v == 0) begin
                rd_addr = 6'd11;
                #1;
                check("nom_rd11", rd_data, 16'hA00B);
                rd_addr = 6'd0;
                #1;
                check("nom_rd0", rd_data, 16'hA000);
            end
            if (v == 1) begin
                idle(5);
                check("error_sticky", error, 1);
            end
        end

        // ---------------- mtoe in IDLE is ignored
        mtoe = 1'b1; index = 6'd3; data_in = 16'hBEEF;
        tick();
        mtoe = 1'b0;
        check("idle_mtoe_err", error, 0);
        check("idle_mtoe_busy", busy, 0);
        rd_addr = 6'd3;
        #1;
        check("idle_mtoe_nowrite", rd_data, m_mem[3]);

        // ---------------- premature end in WAIT
        arm_pulse();
        idle(2);
        dma_end = 1'b1;
        tick();
        dma_end = 1'b0;
        check("pre_done", done, 1);
        check("pre_busy", busy, 0);
        check("pre_error", error, 1);
        irq_seen = 1'b0;
        for (int i = 0; i < 3 * TD; i++) begin
            irq_seen |= interrupt;
            tick();
        end
        check("pre_no_irq", irq_seen, 0);
        check("pre_done_low", done, 0);

        // ---------------- mtoe in WAIT: error, no write
        arm_pulse();
        mtoe = 1'b1; index = 6'd2; data_in = 16'h1234;
        tick();
        mtoe = 1'b0;
        m_err = 1'b1;
        check("wait_mtoe_err", error, 1);
        check("wait_mtoe_busy", busy, 1);
        rd_addr = 6'd2;
        #1;
        check("wait_mtoe_nowrite", rd_data, m_mem[2]);
        wait_irq(TD - 1);
        for (int i = 0; i < DEPTH; i++) beat(i, 16'h5000 + 16'(i), i == DEPTH - 1);
        post_end();

        // ---------------- arm while busy, then arm together with dma_end
        start_session();
        beat(0, 16'h6000, 1'b0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_busy_ignored", busy, 1);
        check("arm_busy_wc", word_count, m_count);
        for (int i = 1; i < DEPTH; i++) begin
            if (i == DEPTH - 1) arm = 1'b1;
            beat(i, 16'h6000 + 16'(i), i == DEPTH - 1);
            arm = 1'b0;
        end
        idle(3);
        check("arm_end_dropped", busy, 0);
        readback();

        // ---------------- reset in the middle of RECV
        start_session();
        for (int i = 0; i < 5; i++) beat(i, 16'h7000 + 16'(i), 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_wc", word_count, 0);
        check("midrst_err", error, 0);
        check("midrst_irq", interrupt, 0);
        tick();
        reset_n = 1'b1;
        model_clear_mem();
        m_count = 0;
        readback();
        full_session(16'hA000);
        check("after_rst_err", error, 0);

        // ---------------- random sessions
        for (int s = 0; s < 20; s++) begin
            bit end_with_beat;
            q.delete();
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < DEPTH; i++) perm[i] = i;
                for (int i = DEPTH - 1; i > 0; i--) begin
                    int j, t;
                    j = $urandom_range(0, i);
                    t = perm[i]; perm[i] = perm[j]; perm[j] = t;
                end
                for (int i = 0; i < DEPTH; i++) q.push_back(perm[i]);
                for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                    q.insert($urandom_range(0, q.size()), $urandom_range(0, 13));
                end
            end else begin
                int nb;
                nb = $urandom_range(1, 20);
                for (int i = 0; i < nb; i++) q.push_back($urandom_range(0, 13));
            end
            end_with_beat = $urandom_range(0, 1) == 1;
            start_session();
            for (int j = 0; j < q.size(); j++) begin
                idle($urandom_range(0, 2));
                beat(q[j], WS'($urandom), end_with_beat && (j == q.size() - 1));
            end
            if (!end_with_beat) end_only();
            post_end();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
